// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile scheduler: element defaults, FSM states, lane packing.
package systolic_pkg;

  localparam int SIZE_DEF    = 8;
  localparam int DECIMAL_DEF = 4;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_e;

  typedef logic [SIZE_DEF-1:0] elem_t;

  // Lanes are row-major, MSB first: lane 0 = e00 ... lane 3 = e11.
  function automatic int lane_lsb(input int lane, input int size);
    return (3 - lane) * size;
  endfunction

  function automatic elem_t lane_unpack(input logic [4*SIZE_DEF-1:0] tile, input int lane);
    return tile[lane_lsb(lane, SIZE_DEF) +: SIZE_DEF];
  endfunction

  function automatic logic [4*SIZE_DEF-1:0] lane_pack(input elem_t e00, input elem_t e01,
                                                      input elem_t e10, input elem_t e11);
    return {e00, e01, e10, e11};
  endfunction

endpackage

// File: rtl/systolic_tile_sched_tile_acc.sv
// Four-lane clear/accumulate register for one C tile; lanes add independently.
// Build option: SYSTOLIC_SAT_ACC_EN makes each lane saturate as signed instead of wrapping.
module tile_acc
  import systolic_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [4*SIZE-1:0] add,
  output logic [4*SIZE-1:0] acc
);

  logic [4*SIZE-1:0] acc_q, acc_d;
  logic [SIZE-1:0]   lane_nxt [4];

  for (genvar l = 0; l < 4; l++) begin : g_lane
    localparam int LSB = lane_lsb(l, SIZE);
    logic [SIZE-1:0] cur, inc;
    assign cur = acc_q[LSB +: SIZE];
    assign inc = add[LSB +: SIZE];
`ifdef SYSTOLIC_SAT_ACC_EN
    logic [SIZE:0] sum;
    assign sum = {cur[SIZE-1], cur} + {inc[SIZE-1], inc};
    // Sign bits disagree only on overflow; clamp toward the sign of the true sum.
    always_comb begin
      lane_nxt[l] = sum[SIZE-1:0];
      if (sum[SIZE] != sum[SIZE-1])
        lane_nxt[l] = sum[SIZE] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
    end
`else
    assign lane_nxt[l] = cur + inc;
`endif
  end

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = {lane_nxt[0], lane_nxt[1], lane_nxt[2], lane_nxt[3]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/systolic_tile_sched.sv
// Tiled C = A x B scheduler for the 2x2 systolic array: fetches tile pairs, accumulates, streams C tiles.
// Build option: SYSTOLIC_SAT_ACC_EN selects saturating accumulation (implemented in tile_acc).
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issue A(i,k) / B(k,j) reads, one k per cycle
// DRAIN | two cycles for the last read and product to reach the accumulator
// OUT   | present C(i,j) until the consumer takes it
module systolic_tile_sched
  import systolic_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int DECIMAL = DECIMAL_DEF,
  parameter int TILES   = 2,
  parameter int AW      = $clog2(TILES*TILES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     a_addr,
  output logic [AW-1:0]     b_addr,
  input  logic [4*SIZE-1:0] a_rdata,
  input  logic [4*SIZE-1:0] b_rdata,
  output logic [4*SIZE-1:0] mi0,
  output logic [4*SIZE-1:0] mi1,
  input  logic [4*SIZE-1:0] mor,
  output logic [4*SIZE-1:0] c_data,
  output logic [AW-1:0]     c_idx,
  output logic              c_valid,
  input  logic              c_ready
);

  if (DECIMAL >= SIZE || TILES < 2) begin : g_bad_param
    $error("systolic_tile_sched: need DECIMAL < SIZE and TILES >= 2");
  end

  localparam logic [AW-1:0] LAST      = AW'(TILES - 1);
  localparam logic [0:0]    DRAIN_TOP = 1'b1;

  function automatic logic [AW-1:0] tile_addr(input logic [AW-1:0] row, input logic [AW-1:0] col);
    return AW'(int'(row) * TILES + int'(col));
  endfunction

  state_e          state_q, state_d;
  logic [AW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [0:0]      drain_q, drain_d;
  logic            v1_q, v1_d, v2_q, v2_d;
  logic            busy_q, busy_d, done_q, done_d, c_valid_q, c_valid_d;
  logic [AW-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_idx_q, c_idx_d;
  logic            acc_clr;
  logic            hs;

  assign hs = c_valid_q && c_ready;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    drain_d = drain_q;
    v1_d    = 1'b0;
    v2_d    = v1_q;
    done_d  = 1'b0;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
        end
      end
      FETCH: begin
        v1_d = 1'b1;
        if (k_q == LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          drain_d = DRAIN_TOP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = OUT;
        else               drain_d = drain_q - 1'b1;
      end
      OUT: begin
        if (hs) begin
          if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          if (i_q == LAST && j_q == LAST) begin
            state_d = IDLE;
            i_d     = '0;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            k_d     = '0;
            acc_clr = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with the state they describe.
    busy_d    = (state_d != IDLE);
    c_valid_d = (state_d == OUT);
    a_addr_d  = (state_d == FETCH) ? tile_addr(i_d, k_d) : '0;
    b_addr_d  = (state_d == FETCH) ? tile_addr(k_d, j_d) : '0;
    c_idx_d   = (state_d == OUT)   ? tile_addr(i_d, j_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      drain_q   <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_valid_q <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      c_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      c_valid_q <= c_valid_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      c_idx_q   <= c_idx_d;
    end
  end

  // Read data goes straight to the array so the product lands one cycle later.
  assign mi0 = v1_q ? a_rdata : '0;
  assign mi1 = v1_q ? b_rdata : '0;

  tile_acc #(.SIZE(SIZE)) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (v2_q),
    .add (mor),
    .acc (c_data)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign c_valid = c_valid_q;
  assign a_addr  = a_addr_q;
  assign b_addr  = b_addr_q;
  assign c_idx   = c_idx_q;

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Self-checking bench for systolic_tile_sched with behavioural tile memories and 2x2 array.
module tb_systolic_tile_sched;

  localparam int SIZE = 8, DECIMAL = 4, TILES = 2, AW = 2, NT = TILES*TILES, W = 4*SIZE;
  localparam int SMAX = (1 << (SIZE-1)) - 1, SMIN = -(1 << (SIZE-1));

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, c_ready = 1'b0;
  logic busy, done, c_valid;
  logic [AW-1:0] a_addr, b_addr, c_idx;
  logic [W-1:0]  a_rdata = '0, b_rdata = '0, mor = '0;
  logic [W-1:0]  mi0, mi1, c_data;
  logic [W-1:0]  mem_a [NT];
  logic [W-1:0]  mem_b [NT];

  int checks = 0, failures = 0, cyc = 0, start_cyc = 0;
  bit mon_en = 1'b0;
  int ncap = 0, done_cnt = 0, done_cyc = -1;
  logic [W-1:0]  cap_data [NT];
  logic [AW-1:0] cap_idx  [NT];
  int            cap_cyc  [NT];

  systolic_tile_sched #(.SIZE(SIZE), .DECIMAL(DECIMAL), .TILES(TILES), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mi0(mi0), .mi1(mi1), .mor(mor), .c_data(c_data), .c_idx(c_idx),
    .c_valid(c_valid), .c_ready(c_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Element (r,c) of a packed 2x2 tile, row-major MSB first.
  function automatic logic signed [SIZE-1:0] el(input logic [W-1:0] t, input int r, input int c);
    logic [W-1:0] s;
    s = t >> ((3 - (2*r + c)) * SIZE);
    return s[SIZE-1:0];
  endfunction

  // Reference 2x2 fixed-point matrix product (the neighbouring array).
  function automatic logic [W-1:0] arr_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] res;
    int s;
    res = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += (int'(el(a, r, k)) * int'(el(b, k, c))) >>> DECIMAL;
        res = {res[W-SIZE-1:0], SIZE'(s)};
      end
    return res;
  endfunction

  function automatic logic [W-1:0] tile_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] res;
    int s;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      s = int'(el(x, l/2, l%2)) + int'(el(y, l/2, l%2));
`ifdef SYSTOLIC_SAT_ACC_EN
      if (s > SMAX) s = SMAX;
      if (s < SMIN) s = SMIN;
`endif
      res = {res[W-SIZE-1:0], SIZE'(s)};
    end
    return res;
  endfunction

  function automatic logic [W-1:0] exp_tile(input int i, input int j);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < TILES; k++) acc = tile_add(acc, arr_mul(mem_a[i*TILES+k], mem_b[k*TILES+j]));
    return acc;
  endfunction

  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
    mor     <= arr_mul(mi0, mi1);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (c_valid && c_ready) begin
        if (ncap < NT) begin
          cap_data[ncap] = c_data;
          cap_idx[ncap]  = c_idx;
          cap_cyc[ncap]  = cyc - start_cyc;
        end
        ncap++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - start_cyc;
      end
    end
  end

  task automatic fill_rand;
    for (int t = 0; t < NT; t++) begin
      mem_a[t] = $urandom();
      mem_b[t] = $urandom();
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready high plus stray start pulses while busy
  task automatic run_job(input int mode);
    ncap = 0; done_cnt = 0; done_cyc = -1;
    @(posedge clk); #1;
    c_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1; start_cyc = cyc; mon_en = 1'b1;
    for (int n = 1; n <= 400 && done_cnt == 0; n++) begin
      @(posedge clk); #1;
      start = (mode == 2 && (n == 3 || n == 10 || n == 12)) ? 1'b1 : 1'b0;
      if (mode == 1) c_ready = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 mon_en = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, done, c_valid} !== 3'b000) begin failures++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, c_valid}); end
    checks++; if ({a_addr, b_addr, c_idx} !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", {a_addr, b_addr, c_idx}); end
    checks++; if ({mi0, mi1, c_data} !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", {mi0, mi1, c_data}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_ones;
    for (int t = 0; t < NT; t++) begin mem_a[t] = 32'h10101010; mem_b[t] = 32'h10101010; end
    run_job(0);
    checks++; if (ncap !== NT) begin failures++; $display("FAIL ones_count: got %0d want %0d", ncap, NT); end
    for (int t = 0; t < NT && t < ncap; t++) begin
      checks++; if (cap_data[t] !== 32'h40404040) begin failures++; $display("FAIL ones_data[%0d]: got %h want 40404040", t, cap_data[t]); end
      checks++; if (cap_idx[t] !== AW'(t)) begin failures++; $display("FAIL ones_idx[%0d]: got %0d want %0d", t, cap_idx[t], t); end
      checks++; if (cap_cyc[t] !== 5*(t+1)) begin failures++; $display("FAIL ones_cycle[%0d]: got %0d want %0d", t, cap_cyc[t], 5*(t+1)); end
    end
    checks++; if (done_cnt !== 1 || done_cyc !== 5*NT+1) begin failures++; $display("FAIL ones_done: got count %0d cycle %0d want 1 at %0d", done_cnt, done_cyc, 5*NT+1); end
  endtask

  task automatic test_identity;
    logic [W-1:0] t_b;
    for (int i = 0; i < TILES; i++)
      for (int j = 0; j < TILES; j++) begin
        mem_a[i*TILES+j] = (i == j) ? 32'h10000010 : 32'h0;
        t_b = '0;
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) t_b = {t_b[W-SIZE-1:0], SIZE'(((2*i + r)*4 + 2*j + c) * 16)};
        mem_b[i*TILES+j] = t_b;
      end
    run_job(0);
    checks++; if (ncap !== NT) begin failures++; $display("FAIL ident_count: got %0d want %0d", ncap, NT); end
    for (int t = 0; t < NT && t < ncap; t++) begin
      checks++; if (cap_data[t] !== mem_b[t] || cap_idx[t] !== AW'(t)) begin failures++; $display("FAIL ident_tile[%0d]: got %h idx %0d want %h idx %0d", t, cap_data[t], cap_idx[t], mem_b[t], t); end
    end
  endtask

  task automatic test_wrap;
    logic [W-1:0] want;
`ifdef SYSTOLIC_SAT_ACC_EN
    want = 32'h7F7F7F7F;
`else
    want = 32'h80808080;
`endif
    for (int t = 0; t < NT; t++) begin mem_a[t] = 32'h20202020; mem_b[t] = 32'h10101010; end
    run_job(0);
    checks++; if (ncap !== NT) begin failures++; $display("FAIL wrap_count: got %0d want %0d", ncap, NT); end
    for (int t = 0; t < NT && t < ncap; t++) begin
      checks++; if (cap_data[t] !== want) begin failures++; $display("FAIL wrap_data[%0d]: got %h want %h", t, cap_data[t], want); end
    end
  endtask

  task automatic test_random;
    for (int rep = 0; rep < 3; rep++) begin
      fill_rand();
      run_job(1);
      checks++; if (ncap !== NT || done_cnt !== 1) begin failures++; $display("FAIL rand_count[%0d]: got tiles %0d done %0d want %0d and 1", rep, ncap, done_cnt, NT); end
      for (int t = 0; t < NT && t < ncap; t++) begin
        checks++; if (cap_data[t] !== exp_tile(t/TILES, t%TILES) || cap_idx[t] !== AW'(t)) begin
          failures++; $display("FAIL rand_tile[%0d.%0d]: got %h idx %0d want %h idx %0d", rep, t, cap_data[t], cap_idx[t], exp_tile(t/TILES, t%TILES), t);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int n, rel;
    logic [W-1:0] want0;
    fill_rand();
    want0 = exp_tile(0, 0);
    ncap = 0; done_cnt = 0; done_cyc = -1;
    @(posedge clk); #1;
    c_ready = 1'b0; start = 1'b1; start_cyc = cyc; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!c_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (c_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid: got %b want 1 within budget", c_valid); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (c_valid !== 1'b1 || c_data !== want0 || c_idx !== '0) begin
        failures++; $display("FAIL bp_hold[%0d]: got valid %b data %h idx %0d want 1 %h 0", s, c_valid, c_data, c_idx, want0);
      end
      checks++; if (a_addr !== '0 || b_addr !== '0 || mi0 !== '0 || mi1 !== '0 || busy !== 1'b1) begin
        failures++; $display("FAIL bp_no_fetch[%0d]: got a %0d b %0d mi0 %h busy %b want 0 0 0 1", s, a_addr, b_addr, mi0, busy);
      end
    end
    @(posedge clk); #1;
    c_ready = 1'b1; rel = cyc - start_cyc;
    for (int m = 0; m < 100 && done_cnt == 0; m++) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    checks++; if (ncap !== NT || done_cnt !== 1) begin failures++; $display("FAIL bp_count: got tiles %0d done %0d want %0d and 1", ncap, done_cnt, NT); end
    checks++; if (cap_cyc[0] !== rel || cap_cyc[1] !== rel + 5 || cap_idx[1] !== AW'(1)) begin
      failures++; $display("FAIL bp_resume: got cycles %0d %0d idx %0d want %0d %0d idx 1", cap_cyc[0], cap_cyc[1], cap_idx[1], rel, rel + 5);
    end
    for (int t = 0; t < NT && t < ncap; t++) begin
      checks++; if (cap_data[t] !== exp_tile(t/TILES, t%TILES)) begin failures++; $display("FAIL bp_tile[%0d]: got %h want %h", t, cap_data[t], exp_tile(t/TILES, t%TILES)); end
    end
  endtask

  task automatic test_start_busy;
    fill_rand();
    run_job(2);
    checks++; if (done_cnt !== 1 || done_cyc !== 5*NT+1 || ncap !== NT) begin
      failures++; $display("FAIL busy_start: got done %0d at %0d tiles %0d want 1 at %0d tiles %0d", done_cnt, done_cyc, ncap, 5*NT+1, NT);
    end
    for (int t = 0; t < NT && t < ncap; t++) begin
      checks++; if (cap_data[t] !== exp_tile(t/TILES, t%TILES)) begin failures++; $display("FAIL busy_tile[%0d]: got %h want %h", t, cap_data[t], exp_tile(t/TILES, t%TILES)); end
    end
  endtask

  task automatic test_reset_mid;
    fill_rand();
    ncap = 0; done_cnt = 0; done_cyc = -1;
    @(posedge clk); #1;
    c_ready = 1'b1; start = 1'b1; start_cyc = cyc; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Third tile's DRAIN occupies cycles 13 and 14 after start.
    repeat (12) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || c_valid !== 1'b0 || ncap !== 2) begin failures++; $display("FAIL rmid_pre: got busy %b valid %b tiles %0d want 1 0 2", busy, c_valid, ncap); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, done, c_valid, a_addr, b_addr, c_idx} !== '0) begin failures++; $display("FAIL rmid_ctrl: got %h want 0", {busy, done, c_valid, a_addr, b_addr, c_idx}); end
    checks++; if ({mi0, mi1, c_data} !== '0) begin failures++; $display("FAIL rmid_data: got %h want 0", {mi0, mi1, c_data}); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    checks++; if (done_cnt !== 0 || ncap !== 2 || busy !== 1'b0) begin failures++; $display("FAIL rmid_abandon: got done %0d tiles %0d busy %b want 0 2 0", done_cnt, ncap, busy); end
    fill_rand();
    run_job(0);
    checks++; if (ncap !== NT || done_cnt !== 1 || done_cyc !== 5*NT+1) begin failures++; $display("FAIL rmid_rerun: got tiles %0d done %0d at %0d want %0d 1 at %0d", ncap, done_cnt, done_cyc, NT, 5*NT+1); end
    for (int t = 0; t < NT && t < ncap; t++) begin
      checks++; if (cap_data[t] !== exp_tile(t/TILES, t%TILES) || cap_idx[t] !== AW'(t)) begin failures++; $display("FAIL rmid_tile[%0d]: got %h want %h", t, cap_data[t], exp_tile(t/TILES, t%TILES)); end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_identity();
    test_wrap();
    test_random();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
